// File: rtl/cbus_arbiter_n_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : cbus_arbiter_n_pkg                                      |
// | Brief  : CBus request/response types and arbitration modes.      |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package cbus_arbiter_n_pkg;

    localparam int CBUS_AW = 32;
    localparam int CBUS_DW = 32;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef struct packed {
        logic               valid;
        logic               wen;
        logic [CBUS_AW-1:0] addr;
        logic [CBUS_DW-1:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [CBUS_DW-1:0] rdata;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage : cbus_arbiter_n_pkg
`default_nettype wire

// File: rtl/cbus_arbiter_n_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rr_pick                                                 |
// | Brief  : First set bit of a valid vector searching from ptr,     |
// |          wrapping modulo NUM_CH. Purely combinational.           |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] i_valid,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic              o_found,
    output logic [IDX_W-1:0]  o_idx
);

    int w_cand;

    // Walk the search order backwards so the earliest candidate wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_cand = (int'(i_ptr) + i) % NUM_CH;
            if (i_valid[w_cand[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cbus_arbiter_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : cbus_arbiter_n                                          |
// | Brief  : N-to-1 CBus arbiter, fixed-priority or round-robin,     |
// |          holding a grant until the last response beat.           |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module cbus_arbiter_n
    import cbus_arbiter_n_pkg::*;
#(
    parameter int        NUM_CH   = 2,
    parameter arb_mode_t ARB_MODE = ARB_RR,
    localparam int       IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  cbus_req_t         ireqs  [NUM_CH],
    output cbus_resp_t        iresps [NUM_CH],
    output cbus_req_t         oreq,
    input  cbus_resp_t        oresp,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx
);

    localparam logic [IDX_W-1:0] c_last_ch = IDX_W'(NUM_CH - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [IDX_W-1:0]  r_sel;
    logic [IDX_W-1:0]  r_ptr;
    logic [NUM_CH-1:0] w_valid;
    logic [IDX_W-1:0]  w_pick_ptr;
    logic              w_found;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_valid
        assign w_valid[g] = ireqs[g].valid;
    end

    // Fixed priority is round-robin searched from channel 0.
    assign w_pick_ptr = (ARB_MODE == ARB_RR) ? r_ptr : '0;
    assign w_done     = (r_state == ST_BUSY) && oresp.ready && oresp.last;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .i_valid (w_valid),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // sel latches only at grant; ptr advances only at completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= '0;
            r_ptr <= '0;
        end else begin
            if (r_state == ST_IDLE && w_found) begin
                r_sel <= w_pick_idx;
            end
            if (ARB_MODE == ARB_RR && w_done) begin
                r_ptr <= (r_sel == c_last_ch) ? '0 : r_sel + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        oreq        = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            iresps[i] = '0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // Outputs are silenced while reset is held so an aborted burst leaks nothing.
        if (r_state == ST_BUSY && !reset) begin
            oreq          = ireqs[r_sel];
            iresps[r_sel] = oresp;
            grant_valid   = 1'b1;
            grant_idx     = r_sel;
        end
    end

endmodule : cbus_arbiter_n
`default_nettype wire

// File: tb/tb_cbus_arbiter_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_cbus_arbiter_n                                       |
// | Brief  : Directed self-checking bench, RR and FIXED instances.   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_cbus_arbiter_n;
    import cbus_arbiter_n_pkg::*;

    localparam int N = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    cbus_req_t  rr_reqs   [N];
    cbus_resp_t rr_iresps [N];
    cbus_req_t  rr_oreq;
    cbus_resp_t rr_oresp;
    logic       rr_gv;
    logic [1:0] rr_gi;

    cbus_req_t  fx_reqs   [N];
    cbus_resp_t fx_iresps [N];
    cbus_req_t  fx_oreq;
    cbus_resp_t fx_oresp;
    logic       fx_gv;
    logic [1:0] fx_gi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cbus_arbiter_n #(.NUM_CH(N), .ARB_MODE(ARB_RR)) u_rr (
        .clk         (clk),
        .reset       (reset),
        .ireqs       (rr_reqs),
        .iresps      (rr_iresps),
        .oreq        (rr_oreq),
        .oresp       (rr_oresp),
        .grant_valid (rr_gv),
        .grant_idx   (rr_gi)
    );

    cbus_arbiter_n #(.NUM_CH(N), .ARB_MODE(ARB_FIXED)) u_fx (
        .clk         (clk),
        .reset       (reset),
        .ireqs       (fx_reqs),
        .iresps      (fx_iresps),
        .oreq        (fx_oreq),
        .oresp       (fx_oresp),
        .grant_valid (fx_gv),
        .grant_idx   (fx_gi)
    );

    function automatic cbus_req_t mk_req(input int ch);
        cbus_req_t r;
        r.valid = 1'b1;
        r.wen   = ch[0];
        r.addr  = 32'h1000 + 32'(ch * 16);
        r.wdata = 32'hA0A0_0000 | 32'(ch);
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.rdata = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input cbus_req_t obs, input cbus_req_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input cbus_resp_t obs, input cbus_resp_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rr_others_zero(input string tag, input int owner);
        for (int j = 0; j < N; j++) begin
            if (j != owner) chk_resp(tag, rr_iresps[j], '0);
        end
    endtask

    task automatic rr_complete();
        rr_oresp = mk_resp(1'b1, 1'b1, 32'hC0DE);
        tick();
        rr_oresp = '0;
        chk("rr_idle_gap", 32'(rr_gv), 32'd0);
    endtask

    int order [4] = '{1, 3, 1, 3};

    initial begin
        for (int i = 0; i < N; i++) begin
            rr_reqs[i] = '0;
            fx_reqs[i] = '0;
        end
        rr_oresp   = '0;
        fx_oresp   = '0;
        rr_reqs[1] = mk_req(1);
        rr_reqs[3] = mk_req(3);
        fx_reqs[0] = mk_req(0);
        fx_reqs[2] = mk_req(2);

        // Reset held with requests pending: everything quiet.
        tick();
        tick();
        chk("rst_gv", 32'(rr_gv), 32'd0);
        chk("rst_gi", 32'(rr_gi), 32'd0);
        chk_req("rst_oreq", rr_oreq, '0);
        rr_others_zero("rst_iresps", -1);
        chk("rst_fx_gv", 32'(fx_gv), 32'd0);
        reset = 1'b0;

        // Round-robin between ch1 and ch3, single-beat transactions.
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_order_gv", 32'(rr_gv), 32'd1);
            chk("rr_order_gi", 32'(rr_gi), 32'(order[k]));
            chk_req("rr_order_oreq", rr_oreq, mk_req(order[k]));
            rr_oresp = mk_resp(1'b1, 1'b1, 32'h5000 + 32'(k));
            #1;
            chk_resp("rr_order_resp", rr_iresps[order[k]], mk_resp(1'b1, 1'b1, 32'h5000 + 32'(k)));
            rr_others_zero("rr_order_others", order[k]);
            tick();
            rr_oresp = '0;
            chk("rr_order_gap", 32'(rr_gv), 32'd0);
        end

        // ptr=0: grant ch2 and complete, leaving ptr=3.
        rr_reqs[1] = '0;
        rr_reqs[3] = '0;
        rr_reqs[2] = mk_req(2);
        tick();
        chk("rr_ch2_gi", 32'(rr_gi), 32'd2);
        rr_complete();

        // ptr=3 wraps to ch0; completion leaves ptr=1.
        rr_reqs[2] = '0;
        rr_reqs[0] = mk_req(0);
        tick();
        chk("rr_wrap_gi", 32'(rr_gi), 32'd0);
        rr_complete();
        rr_reqs[1] = mk_req(1);
        tick();
        chk("rr_ptr1_gi", 32'(rr_gi), 32'd1);
        rr_complete();

        // ptr=2: four-beat burst on ch2.
        rr_reqs[0] = '0;
        rr_reqs[1] = '0;
        rr_reqs[2] = mk_req(2);
        tick();
        chk("burst_gi", 32'(rr_gi), 32'd2);
        for (int b = 1; b <= 4; b++) begin
            rr_oresp = mk_resp(1'b1, (b == 4), 32'hB000 + 32'(b));
            #1;
            chk_resp("burst_beat", rr_iresps[2], mk_resp(1'b1, (b == 4), 32'hB000 + 32'(b)));
            rr_others_zero("burst_others", 2);
            chk("burst_gv", 32'(rr_gv), 32'd1);
            tick();
            chk("burst_state", 32'(rr_gv), (b < 4) ? 32'd1 : 32'd0);
        end
        rr_oresp   = '0;
        rr_reqs[2] = '0;

        // ptr=3: grant ch1, reset mid-burst, then ptr must be back at 0.
        rr_reqs[1] = mk_req(1);
        tick();
        chk("rst_burst_gi", 32'(rr_gi), 32'd1);
        rr_oresp = mk_resp(1'b1, 1'b0, 32'hD001);
        tick();
        chk("rst_burst_busy", 32'(rr_gv), 32'd1);
        rr_oresp = mk_resp(1'b1, 1'b1, 32'hD002);
        reset = 1'b1;
        #1;
        chk("rst_hold_gv", 32'(rr_gv), 32'd0);
        chk_resp("rst_hold_resp", rr_iresps[1], '0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_after_gv", 32'(rr_gv), 32'd0);
        chk_req("rst_after_oreq", rr_oreq, '0);
        chk_resp("rst_after_resp", rr_iresps[1], '0);
        rr_oresp   = '0;
        rr_reqs[3] = mk_req(3);
        tick();
        chk("rst_rearb_gi", 32'(rr_gi), 32'd1);
        chk("rst_rearb_fx_gi", 32'(fx_gi), 32'd0);
        rr_complete();

        // Fixed priority: ch0 always wins over ch2 (fx already holds ch0).
        for (int k = 0; k < 3; k++) begin
            chk("fx_gv", 32'(fx_gv), 32'd1);
            chk("fx_gi", 32'(fx_gi), 32'd0);
            chk_resp("fx_ch2_quiet", fx_iresps[2], '0);
            fx_oresp = mk_resp(1'b1, 1'b1, 32'hF000 + 32'(k));
            tick();
            fx_oresp = '0;
            chk("fx_gap", 32'(fx_gv), 32'd0);
            if (k == 2) fx_reqs[3] = mk_req(3);
            tick();
        end

        // ch0 owns the bus; ch3 (and ch2) drop valid mid-transaction.
        fx_reqs[3] = '0;
        fx_reqs[2] = '0;
        #1;
        chk_req("fx_hold_oreq", fx_oreq, mk_req(0));
        chk("fx_hold_gi", 32'(fx_gi), 32'd0);
        tick();
        chk_req("fx_hold_oreq2", fx_oreq, mk_req(0));
        fx_oresp = mk_resp(1'b1, 1'b1, 32'hE0E0);
        #1;
        chk_resp("fx_done_resp", fx_iresps[0], mk_resp(1'b1, 1'b1, 32'hE0E0));
        chk_resp("fx_done_ch3", fx_iresps[3], '0);
        tick();
        fx_oresp = '0;
        chk("fx_done_gv", 32'(fx_gv), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cbus_arbiter_n
`default_nettype wire

// File: doc/cbus_arbiter_n.md
CBUS_ARBITER_N -- requirements
Module: cbus_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of upstream CBus channels (legal 2..16).
REQ-002 SHALL have parameter ARB_MODE, default ARB_RR: ARB_FIXED selects lowest index first; ARB_RR selects round-robin.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ireqs, input, cbus_req_t[NUM_CH]: upstream requests.
REQ-006 SHALL have port iresps, output, cbus_resp_t[NUM_CH]: upstream responses.
REQ-007 SHALL have port oreq, output, cbus_req_t: downstream request.
REQ-008 SHALL have port oresp, input, cbus_resp_t: downstream response.
REQ-009 SHALL have port grant_valid, output, 1: a transaction is owned.
REQ-010 SHALL have port grant_idx, output, IDX_W = max(1, clog2(NUM_CH)): owning channel.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE, when any ireqs[i].valid is 1, SHALL latch the selected index into sel and enter BUSY on the next edge; arbitration latency is 1 cycle.
REQ-013 In IDLE, oreq SHALL be all-zero, every iresps[i] SHALL be all-zero, and grant_valid SHALL be 0.
REQ-014 In BUSY, oreq SHALL equal ireqs[sel] combinationally.
REQ-015 In BUSY, iresps[sel] SHALL equal oresp, and every other iresps[j] SHALL be all-zero.
REQ-016 In BUSY, grant_valid SHALL be 1 and grant_idx SHALL equal sel.
REQ-017 BUSY SHALL be left only on a cycle with oresp.ready && oresp.last, returning to IDLE.
REQ-018 There SHALL be no back-to-back grant; at least one IDLE cycle separates transactions.
REQ-019 ARB_FIXED: sel SHALL be the lowest i with ireqs[i].valid.
REQ-020 ARB_RR: sel SHALL be the first valid i searching ptr, ptr+1, ... modulo NUM_CH.
REQ-021 ARB_RR: on transaction completion (REQ-017), ptr SHALL become sel+1, wrapping NUM_CH-1 to 0.
REQ-022 ARB_RR: ptr SHALL change only on completion, never on grant.
REQ-023 Changes to other channels' valid during BUSY SHALL NOT affect sel or the forwarded request.
REQ-024 Masters hold valid and payload stable until their last handshake; the arbiter SHALL NOT check or repair violations.
REQ-025 oresp.ready without last SHALL be forwarded to the owner and SHALL keep the FSM in BUSY (burst beats).

Reset
REQ-026 While reset is 1, the FSM SHALL be IDLE, sel = 0, ptr = 0, grant_valid = 0, grant_idx = 0, oreq all-zero, and iresps all-zero.
REQ-027 Reset asserted during BUSY SHALL abort the transaction on that edge with no completion handshake forwarded afterward.
REQ-028 On the first cycle after reset deassertion, arbitration SHALL proceed per REQ-012.

Structure
REQ-029 arb_mode_t (ARB_FIXED, ARB_RR) SHALL reside in the common package beside cbus_req_t and cbus_resp_t.
REQ-030 The valid-vector rotate-and-find-first SHALL be one sub-module, rr_pick: inputs are a NUM_CH-bit valid vector and ptr; outputs are found and idx; it is purely combinational.
REQ-031 With NUM_CH=2 and ARB_FIXED, the block SHALL be a drop-in replacement for the existing two-channel arbiter in SimTop.

Verification
REQ-032 NUM_CH=4, RR, ch1 and ch3 valid from cycle 0, single-beat each (oresp ready+last one cycle after grant) -> grant order 1, 3, 1, 3; grant_valid low one cycle between grants.
REQ-033 NUM_CH=4, FIXED, ch0 and ch2 continuously valid -> ch0 granted every transaction; ch2 never granted.
REQ-034 Burst len=4 on ch2 with oresp.ready every cycle and last on beat 4 -> FSM BUSY for 4 beats; iresps[2] receives 4 ready pulses; iresps[0,1,3] stay zero.
REQ-035 RR with ptr=3 and NUM_CH=4, only ch0 valid -> ch0 granted (wrap); after completion ptr=1.
REQ-036 Reset pulsed mid-burst on ch1 -> next cycle grant_valid=0 and oreq zero; afterward ch1 is re-arbitrated with ptr=0.
REQ-037 ch3 deasserts valid while ch0 is BUSY -> oreq unchanged and completion unaffected.
